// File: rtl/prpg_pkg.sv
// Shared types for the PRPG sequencer: instruction fields, opcodes, FSM states
// and the decoded control vector.
package prpg_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned OPND_W  = 8;
  localparam int unsigned INSTR_W = OPC_W + OPND_W;
  localparam int unsigned TAP_W   = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned HD_W    = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_HALT  = 6'h00,
    OP_CFG   = 6'h01,
    OP_SEED  = 6'h02,
    OP_RUN   = 6'h03,
    OP_SETA  = 6'h04,
    OP_STORE = 6'h05,
    OP_ADDA  = 6'h06,
    OP_LOAD  = 6'h07,
    OP_STHD  = 6'h08,
    OP_BATCH = 6'h09
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_RUN,
    S_BATCH,
    S_LDWAIT,
    S_HALT
  } state_e;

  typedef struct packed {
    logic cfg;
    logic seed;
    logic run;
    logic seta;
    logic store;
    logic adda;
    logic load;
    logic sthd;
    logic batch;
    logic halt;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/prpg_decode.sv
// Combinational opcode decode into a one-hot control vector; every opcode
// outside the defined set is flagged illegal.
module prpg_decode
  import prpg_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HALT:  ctrl.halt  = 1'b1;
      OP_CFG:   ctrl.cfg   = 1'b1;
      OP_SEED:  ctrl.seed  = 1'b1;
      OP_RUN:   ctrl.run   = 1'b1;
      OP_SETA:  ctrl.seta  = 1'b1;
      OP_STORE: ctrl.store = 1'b1;
      OP_ADDA:  ctrl.adda  = 1'b1;
      OP_LOAD:  ctrl.load  = 1'b1;
      OP_STHD:  ctrl.sthd  = 1'b1;
      OP_BATCH: ctrl.batch = 1'b1;
      default:  ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/prpg_sequencer.sv
// Microcoded sequencer driving an external LFSR core and pattern memory:
// fetches from an instruction ROM, executes one opcode per FETCH/EXEC pair.
module prpg_sequencer
  import prpg_pkg::*;
#(
  parameter int unsigned PC_W   = 6,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [13:0]        instr,
  output logic               tap_we,
  output logic [6:0]         tap,
  output logic               p_load,
  output logic [7:0]         p_load_data,
  output logic               p_step,
  input  logic [7:0]         p_cur,
  input  logic [7:0]         p_next,
  input  logic [3:0]         hd,
  output logic               mem_we,
  output logic               mem_re,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op
);

  state_e              state, state_nx;
  logic [PC_W-1:0]     pc_nx;
  logic [INSTR_W-1:0]  ir, ir_nx;
  logic [ADDR_W-1:0]   r_addr, r_addr_nx;
  logic [OPND_W-1:0]   cnt, cnt_nx;
  logic                illegal_nx;
  logic [OPND_W-1:0]   operand;
  ctrl_t               ctrl;

  assign operand = ir[OPND_W-1:0];
  assign tap     = ir[TAP_W-1:0];

  prpg_decode u_decode (
    .opcode (ir[INSTR_W-1 -: OPC_W]),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      r_addr     <= '0;
      cnt        <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      ir         <= ir_nx;
      r_addr     <= r_addr_nx;
      cnt        <= cnt_nx;
      illegal_op <= illegal_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_nx       = ir;
    r_addr_nx   = r_addr;
    cnt_nx      = cnt;
    illegal_nx  = illegal_op;
    tap_we      = 1'b0;
    p_load      = 1'b0;
    p_load_data = operand;
    p_step      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = r_addr;
    mem_wdata   = '0;
    busy        = 1'b1;
    halted      = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        busy   = 1'b0;
        halted = (state == S_HALT);
        if (start) begin
          state_nx   = S_FETCH;
          pc_nx      = '0;
          r_addr_nx  = '0;
          illegal_nx = 1'b0;
        end
      end

      S_FETCH: begin
        ir_nx    = instr;
        state_nx = S_EXEC;
      end

      S_EXEC: begin
        // Single-cycle ops fall through to the default advance; multi-cycle
        // ops and halts override pc/state below.
        state_nx = S_FETCH;
        pc_nx    = pc + PC_W'(1);
        if (ctrl.cfg) begin
          tap_we = 1'b1;
        end else if (ctrl.seed) begin
          p_load = 1'b1;
        end else if (ctrl.seta) begin
          r_addr_nx = ADDR_W'(operand);
        end else if (ctrl.store) begin
          mem_we    = 1'b1;
          mem_wdata = p_cur;
        end else if (ctrl.adda) begin
          r_addr_nx = r_addr + ADDR_W'(operand);
        end else if (ctrl.sthd) begin
          mem_we    = 1'b1;
          mem_wdata = {4'b0, hd};
        end else if (ctrl.run || ctrl.batch) begin
          if (operand != '0) begin
            state_nx = ctrl.run ? S_RUN : S_BATCH;
            pc_nx    = pc;
            cnt_nx   = operand;
          end
        end else if (ctrl.load) begin
          mem_re   = 1'b1;
          state_nx = S_LDWAIT;
          pc_nx    = pc;
        end else begin
          illegal_nx = ctrl.illegal ? 1'b1 : illegal_op;
          state_nx   = S_HALT;
          pc_nx      = pc;
        end
      end

      S_RUN, S_BATCH: begin
        p_step = 1'b1;
        cnt_nx = cnt - OPND_W'(1);
        if (state == S_BATCH) begin
          mem_we    = 1'b1;
          mem_wdata = p_next;
          r_addr_nx = r_addr + ADDR_W'(1);
        end
        if (cnt == OPND_W'(1)) begin
          state_nx = S_FETCH;
          pc_nx    = pc + PC_W'(1);
        end
      end

      S_LDWAIT: begin
        p_load      = 1'b1;
        p_load_data = mem_rdata;
        state_nx    = S_FETCH;
        pc_nx       = pc + PC_W'(1);
      end

      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prpg_sequencer.sv
// Scoreboard bench for prpg_sequencer with a ROM, a 1-cycle-latency memory and
// a simple counting P register standing in for the LFSR core (p_next = P + 1).
module tb_prpg_sequencer;

  localparam int unsigned PC_W   = 6;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [PC_W-1:0]   pc;
  logic [13:0]       instr;
  logic              tap_we, p_load, p_step, mem_we, mem_re;
  logic [6:0]        tap;
  logic [7:0]        p_load_data, p_cur, p_next, mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic [3:0]        hd;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy, halted, illegal_op;

  always #5 clk = ~clk;

  prpg_sequencer #(.PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .instr(instr),
    .tap_we(tap_we), .tap(tap), .p_load(p_load), .p_load_data(p_load_data),
    .p_step(p_step), .p_cur(p_cur), .p_next(p_next), .hd(hd),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  logic [13:0] rom [64];
  logic [7:0]  mem [256];
  logic [7:0]  P = '0;

  assign instr  = rom[pc];
  assign p_cur  = P;
  assign p_next = P + 8'd1;
  assign hd     = 4'($countones(p_cur ^ p_next));

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (p_load) P <= p_load_data;
    else if (p_step) P <= P + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= start ? 0 : cyc + 1;

  // kind: 1 tap, 2 load, 3 step, 4 write, 5 read, 6 step+write, 15 bad combo
  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] cyc;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q [$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic expect_ev(input int kind, input int c, input int data);
    ev_t e;
    e.kind = 4'(kind);
    e.cyc  = 16'(c);
    e.data = 16'(data);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  always @(negedge clk) begin
    ev_t act, e;
    if (tap_we | p_load | p_step | mem_we | mem_re) begin
      case ({tap_we, p_load, p_step, mem_we, mem_re})
        5'b10000: begin act.kind = 4'd1; act.data = {9'h0, tap}; end
        5'b01000: begin act.kind = 4'd2; act.data = {8'h0, p_load_data}; end
        5'b00100: begin act.kind = 4'd3; act.data = 16'h0; end
        5'b00010: begin act.kind = 4'd4; act.data = {mem_addr, mem_wdata}; end
        5'b00001: begin act.kind = 4'd5; act.data = {mem_addr, 8'h00}; end
        5'b00110: begin act.kind = 4'd6; act.data = {mem_addr, mem_wdata}; end
        default:  begin act.kind = 4'd15; act.data = {mem_addr, mem_wdata}; end
      endcase
      act.cyc = 16'(cyc);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got kind=%0d cyc=%0d data=%h, required no pulse",
                 act.kind, act.cyc, act.data);
      end else begin
        e = exp_q.pop_front();
        if (act == e) n_pass++;
        else $display("FAIL event: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                      act.kind, act.cyc, act.data, e.kind, e.cyc, e.data);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int exp_pc);
    pulse_start();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_cyc(input string tag, input int target);
    for (int k = 0; k < 400 && cyc != target; k++) @(negedge clk);
    chk({tag, "_reached"}, 64'(cyc), 64'(target));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({busy, halted, illegal_op, tap_we, p_load, p_step, mem_we, mem_re}), 64'd0);
    chk({tag, "_bus"}, 64'({pc, mem_addr, p_load_data, tap, mem_wdata}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    #1 rst = 1'b0;

    // seed FF then run 5
    rom[0] = 14'h02FF; rom[1] = 14'h0305;
    expect_ev(2, 1, 16'h00FF);
    for (int k = 0; k < 5; k++) expect_ev(3, 4 + k, 0);
    run_to_halt("t1", 2);

    // batch of 6 from 09, then store p_cur at final r_addr
    clear_rom();
    rom[0] = 14'h0210; rom[1] = 14'h0409; rom[2] = 14'h0906; rom[3] = 14'h0500;
    expect_ev(2, 1, 16'h0010);
    for (int k = 0; k < 6; k++) expect_ev(6, 6 + k, ((9 + k) << 8) | (8'h11 + k));
    expect_ev(4, 13, 16'h0F16);
    run_to_halt("t2", 4);

    // cfg, run 0, address wrap in batch, add-to-address, store hd
    clear_rom();
    rom[0] = 14'h0155; rom[1] = 14'h0300; rom[2] = 14'h0200; rom[3] = 14'h04FE;
    rom[4] = 14'h0903; rom[5] = 14'h0610; rom[6] = 14'h0800;
    expect_ev(1, 1, 16'h0055);
    expect_ev(2, 5, 16'h0000);
    expect_ev(6, 10, 16'hFE01);
    expect_ev(6, 11, 16'hFF02);
    expect_ev(6, 12, 16'h0003);
    expect_ev(4, 16, 16'h1103);
    run_to_halt("t3", 7);

    // load from memory
    clear_rom();
    mem[8'h0D] = 8'hA5;
    rom[0] = 14'h040D; rom[1] = 14'h0700;
    expect_ev(5, 3, 16'h0D00);
    expect_ev(2, 4, 16'h00A5);
    run_to_halt("t4", 2);

    // illegal opcode, then restart
    clear_rom();
    rom[0] = 14'h3F00;
    run_to_halt("t5", 0);
    chk("t5_illegal", 64'(illegal_op), 64'd1);
    rom[0] = 14'h0000;
    pulse_start();
    chk("t5_restart", 64'({illegal_op, busy, pc}), 64'({1'b0, 1'b1, 6'd0}));
    run_to_halt("t5b", 0);

    // pc wraps 63 -> 0 without halting; stopped by reset
    for (int i = 0; i < 64; i++) begin
      rom[i] = {6'h01, 8'(i)};
      expect_ev(1, 2 * i + 1, i);
    end
    expect_ev(1, 129, 0);
    pulse_start();
    wait_cyc("t6", 128);
    chk("t6_wrap", 64'({halted, busy, pc}), 64'({1'b0, 1'b1, 6'd0}));
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_idle("t6_rst");
    #1 rst = 1'b0;
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // reset during third cycle of a 10-step batch
    clear_rom();
    rom[0] = 14'h0200; rom[1] = 14'h0420; rom[2] = 14'h090A;
    expect_ev(2, 1, 16'h0000);
    expect_ev(6, 6, 16'h2001);
    expect_ev(6, 7, 16'h2102);
    expect_ev(6, 8, 16'h2203);
    pulse_start();
    wait_cyc("t7", 8);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_idle("t7_rst");
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t7_quiet", 64'({mem_we, p_step, busy}), 64'd0);
    end
    chk("t7_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
